// File: rtl/column_pkg.sv
// rtl/column_pkg.sv - shared state type, default constants and priority helper for the column sequencer
package column_pkg;
   localparam int P         = 64;
   localparam int Q         = 2;
   localparam int TRES      = 3;
   localparam int PULSE_W   = 8;
   localparam int GAMMA_LEN = 32;
   localparam int CNT_W     = $clog2(GAMMA_LEN);
   localparam int QIDX_W    = $clog2(Q);

   typedef enum logic [2:0] {INIT, IDLE, GRST, RUN, REPORT} seq_state_t;

   // Lowest set index among the first n bits of v; 0 when none are set.
   function automatic int lowest_index(input logic [63:0] v, input int n);
      int idx;
      idx = 0;
      for (int i = 63; i >= 0; i--) begin
         if (i < n && v[i[5:0]]) idx = i;
      end
      return idx;
   endfunction
endpackage

// File: rtl/spike_encoder.sv
// rtl/spike_encoder.sv - per-lane pulse window comparator for one input line
module spike_encoder #(
   parameter int TRES    = 3,
   parameter int PULSE_W = 8,
   parameter int CNT_W   = 5
) (
   input  logic             i_run,
   input  logic [CNT_W-1:0] i_cnt,
   input  logic [TRES-1:0]  i_time,
   input  logic             i_nospike,
   output logic             o_spike
);
   localparam int BASE_W = TRES + $clog2(PULSE_W) + 1;
   // Wide enough for t+PULSE_W and for the full counter range, so neither side wraps.
   localparam int CMP_W  = (CNT_W > BASE_W) ? CNT_W : BASE_W;

   logic [CMP_W-1:0] w_cnt;
   logic [CMP_W-1:0] w_lo;
   logic [CMP_W-1:0] w_hi;

   assign w_cnt   = CMP_W'(i_cnt);
   assign w_lo    = CMP_W'(i_time) + CMP_W'(1);
   assign w_hi    = CMP_W'(i_time) + CMP_W'(PULSE_W);
   assign o_spike = i_run & ~i_nospike & (w_cnt >= w_lo) & (w_cnt <= w_hi);
endmodule

// File: rtl/column_sequencer.sv
// rtl/column_sequencer.sv - wave-level controller for one TNN column
// Optional wave/fire counters: define COLUMN_SEQ_WAVE_COUNT_EN.
module column_sequencer #(
   parameter int P         = column_pkg::P,
   parameter int Q         = column_pkg::Q,
   parameter int TRES      = column_pkg::TRES,
   parameter int PULSE_W   = column_pkg::PULSE_W,
   parameter int GAMMA_LEN = column_pkg::GAMMA_LEN
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [P-1:0][TRES-1:0]        in_times,
   input  logic [P-1:0]                  in_nospike,
   output logic                          grst,
   output logic [P-1:0]                  input_spikes,
   input  logic [Q-1:0]                  output_spikes,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(Q)-1:0]          out_winner,
   output logic [$clog2(GAMMA_LEN)-1:0]  out_time,
   output logic                          out_none
`ifdef COLUMN_SEQ_WAVE_COUNT_EN
   ,
   output logic [15:0]                   wave_count,
   output logic [15:0]                   fire_count
`endif
);
   import column_pkg::*;

   localparam int CW = $clog2(GAMMA_LEN);
   localparam int QW = $clog2(Q);

   if (GAMMA_LEN < 1 + (2**TRES - 1) + PULSE_W + 1) begin : g_gamma_check
      $error("GAMMA_LEN too short for the latest pulse to end inside RUN");
   end

   seq_state_t             r_state;
   seq_state_t             w_next;
   logic [CW-1:0]          r_cnt;
   logic [P-1:0][TRES-1:0] r_times;
   logic [P-1:0]           r_nospike;
   logic                   r_captured;
   logic                   r_in_ready;
   logic                   r_grst;
   logic                   r_out_valid;
   logic                   r_out_none;
   logic [QW-1:0]          r_winner;
   logic [CW-1:0]          r_time;
   logic                   w_run;
   logic                   w_accept;
   logic                   w_last;
   logic                   w_any;
   logic [QW-1:0]          w_low;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= INIT;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         INIT:    w_next = IDLE;
         IDLE:    if (w_accept) w_next = GRST;
         GRST:    w_next = RUN;
         RUN:     if (w_last) w_next = REPORT;
         REPORT:  if (out_ready) w_next = IDLE;
         default: w_next = INIT;
      endcase
   end

   always_comb begin
      w_run    = (r_state == RUN);
      w_accept = (r_state == IDLE) & in_valid & r_in_ready;
      w_last   = w_run & (r_cnt == CW'(GAMMA_LEN - 1));
      w_any    = |output_spikes;
      w_low    = QW'(lowest_index(64'(output_spikes), Q));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_times     <= '0;
         r_nospike   <= '0;
         r_captured  <= 1'b0;
         r_in_ready  <= 1'b0;
         r_grst      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_none  <= 1'b0;
         r_winner    <= '0;
         r_time      <= '0;
      end else begin
         case (r_state)
            INIT: begin
               r_grst     <= 1'b1;
               r_in_ready <= 1'b1;
            end
            IDLE: begin
               r_grst <= w_accept;
               if (w_accept) begin
                  r_times    <= in_times;
                  r_nospike  <= in_nospike;
                  r_in_ready <= 1'b0;
                  r_captured <= 1'b0;
                  r_out_none <= 1'b0;
                  r_winner   <= '0;
                  r_time     <= '0;
               end
            end
            GRST: begin
               r_grst <= 1'b0;
               r_cnt  <= '0;
            end
            RUN: begin
               r_cnt <= r_cnt + CW'(1);
               if (!r_captured && w_any) begin
                  r_captured <= 1'b1;
                  r_winner   <= w_low;
                  r_time     <= r_cnt;
               end
               // A spike on the final RUN cycle is captured above and still counts as a fire.
               if (w_last) begin
                  r_out_valid <= 1'b1;
                  r_out_none  <= ~(r_captured | w_any);
                  if (!(r_captured | w_any)) begin
                     r_winner <= '0;
                     r_time   <= '1;
                  end
               end
            end
            REPORT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar j = 0; j < P; j++) begin : g_lane
      spike_encoder #(.TRES(TRES), .PULSE_W(PULSE_W), .CNT_W(CW)) u_enc (
         .i_run     (w_run),
         .i_cnt     (r_cnt),
         .i_time    (r_times[j]),
         .i_nospike (r_nospike[j]),
         .o_spike   (input_spikes[j])
      );
   end

`ifdef COLUMN_SEQ_WAVE_COUNT_EN
   logic [15:0] r_wave_count;
   logic [15:0] r_fire_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wave_count <= '0;
         r_fire_count <= '0;
      end else if (w_last) begin
         if (r_wave_count != 16'hFFFF) r_wave_count <= r_wave_count + 16'd1;
         if ((r_captured | w_any) && r_fire_count != 16'hFFFF) r_fire_count <= r_fire_count + 16'd1;
      end
   end

   assign wave_count = r_wave_count;
   assign fire_count = r_fire_count;
`endif

   assign in_ready   = r_in_ready;
   assign grst       = r_grst;
   assign out_valid  = r_out_valid;
   assign out_winner = r_winner;
   assign out_time   = r_time;
   assign out_none   = r_out_none;
endmodule
